// File: rtl/imuldiv_muldiv_dispatch.sv
// rtl/imuldiv_muldiv_dispatch.sv - mul/div request steering with in-order response merge
// A tag FIFO records the kind of each accepted op; its head selects which unit may respond.
module imuldiv_muldiv_dispatch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,
  output logic [31:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,
  output logic        divreq_msg_signed,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {K_MUL, K_QUO, K_REM, K_ILL} kind_t;

  kind_t          r_kind [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           w_full;
  logic           w_empty;
  logic           w_is_mul;
  logic           w_is_div;
  logic           w_push;
  logic           w_pop;
  kind_t          w_push_kind;
  kind_t          w_head_kind;
  logic           w_unused_mul_hi;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_is_mul = (muldivreq_msg_fn == FN_MUL);
  assign w_is_div = (muldivreq_msg_fn == FN_DIV)  || (muldivreq_msg_fn == FN_DIVU) ||
                    (muldivreq_msg_fn == FN_REM)  || (muldivreq_msg_fn == FN_REMU);

  assign mulreq_msg_a      = muldivreq_msg_a;
  assign mulreq_msg_b      = muldivreq_msg_b;
  assign divreq_msg_a      = muldivreq_msg_a;
  assign divreq_msg_b      = muldivreq_msg_b;
  assign divreq_msg_signed = (muldivreq_msg_fn == FN_DIV) || (muldivreq_msg_fn == FN_REM);

  // Unit valids never look at the unit's own ready, so no combinational loop forms through it.
  assign mulreq_val    = muldivreq_val && !w_full && w_is_mul;
  assign divreq_val    = muldivreq_val && !w_full && w_is_div;
  assign muldivreq_rdy = !w_full && (w_is_mul ? mulreq_rdy : (w_is_div ? divreq_rdy : 1'b1));

  assign w_push = muldivreq_val && muldivreq_rdy;
  assign w_pop  = muldivresp_val && muldivresp_rdy;

  always_comb begin
    w_push_kind = K_ILL;
    case (muldivreq_msg_fn)
      FN_MUL:          w_push_kind = K_MUL;
      FN_DIV, FN_DIVU: w_push_kind = K_QUO;
      FN_REM, FN_REMU: w_push_kind = K_REM;
      default:         w_push_kind = K_ILL;
    endcase
  end

  assign w_head_kind = r_kind[r_rd_ptr];

  // Only the unit matching the head kind is acked; the other holds its result until its turn.
  always_comb begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = 32'h0;
    mulresp_rdy           = 1'b0;
    divresp_rdy           = 1'b0;
    if (!w_empty) begin
      case (w_head_kind)
        K_MUL: begin
          muldivresp_val        = mulresp_val;
          muldivresp_msg_result = mulresp_msg_result[31:0];
          mulresp_rdy           = muldivresp_rdy;
        end
        K_QUO: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = divresp_msg_result[31:0];
          divresp_rdy           = muldivresp_rdy;
        end
        K_REM: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = divresp_msg_result[63:32];
          divresp_rdy           = muldivresp_rdy;
        end
        default: begin
          muldivresp_val        = 1'b1;
          muldivresp_msg_result = 32'h0;
        end
      endcase
    end
  end

  assign w_unused_mul_hi = ^mulresp_msg_result[63:32];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_kind[r_wr_ptr] <= w_push_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb/tb_imuldiv_muldiv_dispatch.sv - randomized bench with unit models and in-order result model
module tb_imuldiv_muldiv_dispatch;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic [31:0] mulreq_msg_a;
  logic [31:0] mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val;
  logic        mulresp_rdy;
  logic        divreq_msg_signed;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  imuldiv_muldiv_dispatch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy), .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy), .divreq_msg_signed(divreq_msg_signed),
    .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    int          rdy_cyc;
  } pend_t;

  pend_t       mq[$];
  pend_t       dq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          cyc = 0;
  int          mul_lat = 1;
  int          div_lat = 3;
  bit          lat_rand = 0;
  bit          rand_unit_rdy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (fn)
      3'd0:    ref_result = a * b;
      3'd1:    ref_result = sa / sb;
      3'd2:    ref_result = a / b;
      3'd3:    ref_result = sa % sb;
      3'd4:    ref_result = a % b;
      default: ref_result = 32'h0;
    endcase
  endfunction

  // Behavioural mul/div units: unbounded in-order pipelines with configurable latency.
  initial begin : unit_models
    bit          m_req_f, m_resp_f, d_req_f, d_resp_f, clr_f;
    logic [63:0] m_new, d_new;
    pend_t       p;
    m_req_f = 0; m_resp_f = 0; d_req_f = 0; d_resp_f = 0; clr_f = 0;
    m_new = '0; d_new = '0;
    mulreq_rdy = 1'b1; divreq_rdy = 1'b1;
    mulresp_val = 1'b0; divresp_val = 1'b0;
    mulresp_msg_result = '0; divresp_msg_result = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_f) begin
        mq.delete();
        dq.delete();
      end else begin
        if (m_resp_f) void'(mq.pop_front());
        if (d_resp_f) void'(dq.pop_front());
        if (m_req_f) begin
          p.res = m_new;
          p.rdy_cyc = cyc + (lat_rand ? $urandom_range(1, 5) : mul_lat) - 1;
          if (mq.size() > 0 && p.rdy_cyc < mq[mq.size()-1].rdy_cyc) p.rdy_cyc = mq[mq.size()-1].rdy_cyc;
          mq.push_back(p);
        end
        if (d_req_f) begin
          p.res = d_new;
          p.rdy_cyc = cyc + (lat_rand ? $urandom_range(1, 12) : div_lat) - 1;
          if (dq.size() > 0 && p.rdy_cyc < dq[dq.size()-1].rdy_cyc) p.rdy_cyc = dq[dq.size()-1].rdy_cyc;
          dq.push_back(p);
        end
      end
      if (rand_unit_rdy) begin
        mulreq_rdy = ($urandom_range(0, 3) != 0);
        divreq_rdy = ($urandom_range(0, 3) != 0);
      end
      mulresp_val = (mq.size() > 0) && (cyc >= mq[0].rdy_cyc);
      mulresp_msg_result = (mq.size() > 0) ? mq[0].res : 64'h0;
      divresp_val = (dq.size() > 0) && (cyc >= dq[0].rdy_cyc);
      divresp_msg_result = (dq.size() > 0) ? dq[0].res : 64'h0;
      #2;
      clr_f    = reset;
      m_req_f  = mulreq_val && mulreq_rdy;
      m_resp_f = mulresp_val && mulresp_rdy;
      d_req_f  = divreq_val && divreq_rdy;
      d_resp_f = divresp_val && divresp_rdy;
      m_new = {{32{mulreq_msg_a[31]}}, mulreq_msg_a} * {{32{mulreq_msg_b[31]}}, mulreq_msg_b};
      if (divreq_msg_signed)
        d_new = {32'($signed(divreq_msg_a) % $signed(divreq_msg_b)),
                 32'($signed(divreq_msg_a) / $signed(divreq_msg_b))};
      else
        d_new = {divreq_msg_a % divreq_msg_b, divreq_msg_a / divreq_msg_b};
    end
  end

  // Records accepted requests as expected results and popped responses as observed results.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        got_q.delete();
      end else begin
        if (muldivreq_val && muldivreq_rdy)
          exp_q.push_back(ref_result(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
        if (muldivresp_val && muldivresp_rdy) got_q.push_back(muldivresp_msg_result);
      end
    end
  end

  task automatic rand_op(output logic [2:0] fn, output logic [31:0] a, output logic [31:0] b);
    fn = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = $urandom;
    if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 20));
    if (b == 32'h0) b = 32'd1;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
  endtask

  task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                      output logic sig);
    bit ok;
    ok = 0;
    sig = 1'bx;
    muldivreq_msg_fn = fn;
    muldivreq_msg_a  = a;
    muldivreq_msg_b  = b;
    muldivreq_val    = 1'b1;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (muldivreq_rdy) begin
        ok = 1;
        sig = divreq_msg_signed;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    muldivreq_val = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept fn=%0d accepted=%0b required=1", fn, ok);
    end
  endtask

  task automatic wait_val(input int lim, output bit ok);
    ok = 0;
    for (int t = 0; t < lim; t++) begin
      #1;
      if (muldivresp_val) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int lim);
    bit ok;
    ok = 0;
    muldivresp_rdy = 1'b1;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (got_q.size() == exp_q.size()) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain got=%0d required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    muldivreq_val = 1'b0; muldivreq_msg_fn = 3'd0;
    muldivreq_msg_a = '0; muldivreq_msg_b = '0;
    muldivresp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 5;
    if (muldivresp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val got=%b required=0", muldivresp_val); end
    if (muldivresp_msg_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h required=0", muldivresp_msg_result); end
    if (mulreq_val !== 1'b0) begin errors++; $display("FAIL reset_mulreq_val got=%b required=0", mulreq_val); end
    if (divreq_val !== 1'b0) begin errors++; $display("FAIL reset_divreq_val got=%b required=0", divreq_val); end
    if (muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got=%b required=1", muldivreq_rdy); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic sig;
    bit   ok;
    muldivresp_rdy = 1'b0;
    send(3'd0, 32'd7, 32'hFFFF_FFFD, sig);
    wait_val(10, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL mul_val_timeout got=0 required=1"); end
    if (muldivresp_msg_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h required=ffffffeb", muldivresp_msg_result); end
    if (mulresp_rdy !== 1'b0) begin errors++; $display("FAIL mul_rdy_hold got=%b required=0", mulresp_rdy); end
    muldivresp_rdy = 1'b1;
    #1;
    checks++;
    if (mulresp_rdy !== 1'b1) begin errors++; $display("FAIL mul_rdy_pulse got=%b required=1", mulresp_rdy); end
    @(negedge clk);
    muldivresp_rdy = 1'b0;
    #1;
    checks++;
    if (muldivresp_val !== 1'b0) begin errors++; $display("FAIL mul_popped got=%b required=0", muldivresp_val); end
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      logic [31:0] want;
      want = (k == 0) ? 32'hFFFF_FFFF : 32'h7FFF_FFFC;
      send((k == 0) ? 3'd3 : 3'd2, 32'hFFFF_FFF9, 32'd2, sig);
      wait_val(20, ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL div_val_timeout k=%0d got=0 required=1", k); end
      if (sig !== ((k == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL div_signed k=%0d got=%b required=%0d", k, sig, (k == 0)); end
      if (muldivresp_msg_result !== want) begin errors++; $display("FAIL div_result k=%0d got=%h required=%h", k, muldivresp_msg_result, want); end
      muldivresp_rdy = 1'b1;
      @(negedge clk);
      muldivresp_rdy = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic sig;
    muldivresp_rdy = 1'b0;
    send(3'd6, 32'h1234, 32'h5678, sig);
    muldivresp_rdy = 1'b1;
    #1;
    checks += 4;
    if (muldivresp_val !== 1'b1) begin errors++; $display("FAIL ill_val got=%b required=1", muldivresp_val); end
    if (muldivresp_msg_result !== 32'h0) begin errors++; $display("FAIL ill_result got=%h required=0", muldivresp_msg_result); end
    if (mulresp_rdy !== 1'b0) begin errors++; $display("FAIL ill_mulresp_rdy got=%b required=0", mulresp_rdy); end
    if (divresp_rdy !== 1'b0) begin errors++; $display("FAIL ill_divresp_rdy got=%b required=0", divresp_rdy); end
    @(negedge clk);
    #1;
    checks++;
    if (muldivresp_val !== 1'b0) begin errors++; $display("FAIL ill_popped got=%b required=0", muldivresp_val); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic sig;
    bit   held;
    held = 0;
    exp_q.delete(); got_q.delete();
    mul_lat = 1; div_lat = 33;
    muldivresp_rdy = 1'b1;
    send(3'd1, 32'd100, 32'd7, sig);
    send(3'd0, 32'd5, 32'd6, sig);
    for (int t = 0; t < 60 && got_q.size() < 2; t++) begin
      #1;
      if (mulresp_val && got_q.size() == 0) begin
        held = 1;
        checks++;
        if (mulresp_rdy !== 1'b0) begin errors++; $display("FAIL order_mul_held got=%b required=0", mulresp_rdy); end
      end
      @(negedge clk);
    end
    drain(10);
    checks += 4;
    if (!held) begin errors++; $display("FAIL order_mul_waiting got=0 required=1"); end
    if (got_q.size() != 2) begin errors++; $display("FAIL order_count got=%0d required=2", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== 32'd14) begin errors++; $display("FAIL order_first got=%h required=e", got_q[0]); end
    if (got_q.size() > 1 && got_q[1] !== 32'd30) begin errors++; $display("FAIL order_second got=%h required=1e", got_q[1]); end
    div_lat = 3;
  endtask

  task automatic test_full();
    logic [2:0]  fn;
    logic [31:0] a, b;
    logic        sig;
    exp_q.delete(); got_q.delete();
    mul_lat = 1; div_lat = 2;
    muldivresp_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rand_op(fn, a, b);
      send(fn, a, b, sig);
    end
    for (int i = 0; i < 10; i++) begin
      rand_op(fn, a, b);
      muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
      muldivreq_val = 1'b1;
      #1;
      checks += 3;
      if (muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL full_req_rdy i=%0d got=%b required=0", i, muldivreq_rdy); end
      if (mulreq_val !== 1'b0) begin errors++; $display("FAIL full_mulreq_val i=%0d got=%b required=0", i, mulreq_val); end
      if (divreq_val !== 1'b0) begin errors++; $display("FAIL full_divreq_val i=%0d got=%b required=0", i, divreq_val); end
      repeat (4) @(negedge clk);
      muldivresp_rdy = 1'b1;
      #1;
      checks += 2;
      if (muldivresp_val !== 1'b1) begin errors++; $display("FAIL full_head_val i=%0d got=%b required=1", i, muldivresp_val); end
      if (muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL full_no_push_on_pop i=%0d got=%b required=0", i, muldivreq_rdy); end
      @(negedge clk);
      muldivresp_rdy = 1'b0;
      #1;
      checks++;
      if (muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL full_accept_after_pop i=%0d got=%b required=1", i, muldivreq_rdy); end
      @(negedge clk);
      muldivreq_val = 1'b0;
    end
    drain(100);
    checks++;
    if (got_q.size() != 12) begin errors++; $display("FAIL full_total got=%0d required=12", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL full_result k=%0d got=%h required=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  fn;
    logic [31:0] a, b;
    int          outst;
    bit          acc;
    logic        e_mv, e_dv, e_rdy;
    exp_q.delete(); got_q.delete();
    lat_rand = 1; rand_unit_rdy = 1;
    muldivreq_val = 1'b0;
    acc = 0;
    for (int t = 0; t < 600; t++) begin
      if (acc) muldivreq_val = 1'b0;
      muldivresp_rdy = ($urandom_range(0, 3) != 0);
      if (!muldivreq_val && $urandom_range(0, 1) == 1 && t < 560) begin
        rand_op(fn, a, b);
        muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
        muldivreq_val = 1'b1;
      end
      #1;
      outst = exp_q.size() - got_q.size();
      e_mv  = muldivreq_val && (outst < DEPTH) && (muldivreq_msg_fn == 3'd0);
      e_dv  = muldivreq_val && (outst < DEPTH) && (muldivreq_msg_fn inside {[3'd1:3'd4]});
      e_rdy = (outst < DEPTH) && ((muldivreq_msg_fn == 3'd0) ? mulreq_rdy :
              (muldivreq_msg_fn inside {[3'd1:3'd4]}) ? divreq_rdy : 1'b1);
      checks += 3;
      if (mulreq_val !== e_mv) begin errors++; $display("FAIL rand_mulreq_val t=%0d got=%b required=%b", t, mulreq_val, e_mv); end
      if (divreq_val !== e_dv) begin errors++; $display("FAIL rand_divreq_val t=%0d got=%b required=%b", t, divreq_val, e_dv); end
      if (muldivreq_rdy !== e_rdy) begin errors++; $display("FAIL rand_req_rdy t=%0d got=%b required=%b", t, muldivreq_rdy, e_rdy); end
      acc = muldivreq_val && muldivreq_rdy;
      @(negedge clk);
    end
    muldivreq_val = 1'b0;
    drain(200);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_total got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_result k=%0d got=%h required=%h", k, got_q[k], exp_q[k]); end
    end
    lat_rand = 0; rand_unit_rdy = 0;
    mulreq_rdy = 1'b1; divreq_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic sig;
    muldivresp_rdy = 1'b0;
    div_lat = 20;
    send(3'd0, 32'd9, 32'd9, sig);
    send(3'd1, 32'd50, 32'd5, sig);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    muldivreq_msg_fn = 3'd0;
    #1;
    checks += 2;
    if (muldivresp_val !== 1'b0) begin errors++; $display("FAIL rst_mid_val got=%b required=0", muldivresp_val); end
    if (muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_req_rdy got=%b required=1", muldivreq_rdy); end
    @(negedge clk);
    exp_q.delete(); got_q.delete();
    send(3'd0, 32'd3, 32'd4, sig);
    drain(20);
    checks += 2;
    if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_count got=%0d required=1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== 32'd12) begin errors++; $display("FAIL rst_mid_mul got=%h required=c", got_q[0]); end
    div_lat = 3;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
Name: imuldiv_muldiv_dispatch

Overview:
- Front-end stage directly upstream of the iterative multiply and divide units.
- Accepts one unified mul/div request stream, decodes the function, and steers operands to the mul unit or the div unit.
- Tracks outstanding operations in an in-order tag FIFO and merges the two unit response streams into one 32-bit response stream, in request order.
- Selects the correct half of each 64-bit unit result.

Parameters:
- DEPTH, 2, maximum outstanding operations (tag FIFO entries); power of two, ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- muldivreq_msg_fn  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5..7 illegal
- muldivreq_msg_a  in  32  operand A
- muldivreq_msg_b  in  32  operand B
- muldivreq_val  in  1  request valid
- muldivreq_rdy  out  1  request ready
- muldivresp_msg_result  out  32  result
- muldivresp_val  out  1  response valid
- muldivresp_rdy  in  1  response ready
- mulreq_msg_a  out  32  to mul unit
- mulreq_msg_b  out  32  to mul unit
- mulreq_val  out  1  to mul unit
- mulreq_rdy  in  1  from mul unit
- mulresp_msg_result  in  64  signed product from mul unit
- mulresp_val  in  1  from mul unit
- mulresp_rdy  out  1  to mul unit
- divreq_msg_signed  out  1  1 for DIV/REM, 0 for DIVU/REMU
- divreq_msg_a  out  32  dividend
- divreq_msg_b  out  32  divisor
- divreq_val  out  1  to div unit
- divreq_rdy  in  1  from div unit
- divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}
- divresp_val  in  1  from div unit
- divresp_rdy  out  1  to div unit

Behaviour:
- Tag FIFO: DEPTH entries of a 2-bit kind (K_MUL, K_QUO, K_REM, K_ILL), with wrapping read/write pointers and a count register of width $clog2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
- Reset: pointers and count go to 0. All outputs are combinational from state and inputs; after reset muldivresp_val=0, mulreq_val=0, divreq_val=0.
- Reset mid-operation discards all tags. The mul and div units share the same reset, so no stale responses can arrive.
- Request side, all combinational, with no registering of operands:
  - mulreq_msg_a/b and divreq_msg_a/b pass muldivreq_msg_a/b through unchanged.
  - divreq_msg_signed = (fn==DIV or fn==REM).
  - mulreq_val = muldivreq_val & !full & fn==MUL.
  - divreq_val = muldivreq_val & !full & fn∈{1..4}.
  - muldivreq_rdy = !full & (fn==MUL ? mulreq_rdy : fn∈{1..4} ? divreq_rdy : 1).
  - mulreq_val/divreq_val must not depend on the unit's own rdy.
- Accept (push) occurs when muldivreq_val & muldivreq_rdy. The pushed kind is MUL→K_MUL, DIV/DIVU→K_QUO, REM/REMU→K_REM, illegal→K_ILL.
- Response side, keyed off the head kind when the FIFO is not empty:
  - K_MUL: muldivresp_val = mulresp_val; result = mulresp_msg_result[31:0]; mulresp_rdy = muldivresp_rdy.
  - K_QUO: val = divresp_val; result = divresp_msg_result[31:0]; divresp_rdy = muldivresp_rdy.
  - K_REM: val = divresp_val; result = divresp_msg_result[63:32]; divresp_rdy = muldivresp_rdy.
  - K_ILL: val = 1; result = 32'h0; neither unit is acked.
  - When empty: val=0, mulresp_rdy=0, divresp_rdy=0, result=0.
  - A unit whose kind is not at the head sees resp_rdy=0. It holds its response, which enforces program order.
- Pop occurs when muldivresp_val & muldivresp_rdy.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, no push even if pop fires that cycle, because rdy is computed from full only.
- Minimum latency is set by the units. An illegal op alone in the FIFO responds the cycle after acceptance.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or underflows.

Test Plan:
- MUL a=7, b=-3; mul unit responds with 64'hFFFF_FFFF_FFFF_FFEB → muldivresp_msg_result = 32'hFFFF_FFEB, mulresp_rdy pulses with the output handshake.
- REM a=-7, b=2 → divreq_msg_signed=1; div returns {32'hFFFF_FFFF, 32'hFFFF_FFFD} → result = 32'hFFFF_FFFF. Same operands as DIVU → signed=0, result taken from the low half.
- Back-to-back DIV (slow, 33 cycles) then MUL (fast) with DEPTH=2 → MUL response is held (mulresp_rdy=0) until the DIV result pops; outputs appear in order DIV, MUL.
- Fill with 2 requests, muldivresp_rdy=0 → third request sees muldivreq_rdy=0 and mulreq_val=0/divreq_val=0. Release rdy for one cycle → one pop, then the third request is accepted the next cycle. Pointers wrap correctly over 10 iterations.
- fn=6 with the FIFO empty → accepted without unit handshakes, result 32'h0 with val=1 next cycle.
- Assert reset with 2 ops outstanding → val low next cycle, count=0, and a fresh MUL 3×4 returns 12.
